// File: rtl/pmt_scan_ctrl.sv
// pmt_scan_ctrl: PMT line-scan sequencer (pre-delay, timed lines, inter-line gaps, end pulse).
// Define SCAN_TIMEOUT_EN to add the session watchdog driven by cfg_timeout_i.
module pmt_scan_ctrl #(
  parameter int unsigned LINE_GAP = 8,
  parameter real TCQ = 0.1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        scan_start_i,
  input  logic        scan_stop_i,
  input  logic [15:0] cfg_pre_delay_i,
  input  logic [31:0] cfg_line_len_i,
  input  logic [15:0] cfg_line_num_i,
  input  logic [31:0] cfg_timeout_i,
  output logic        adc_start_en_o,
  output logic        adc_end_en_o,
  output logic        scan_busy_o,
  output logic        scan_done_o,
  output logic        scan_err_o,
  output logic [15:0] line_cnt_o,
  output logic [2:0]  state_o
);
  typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, LINE = 3'd2, GAP = 3'd3, END = 3'd4} state_t;
  state_t state, state_n;
  logic [31:0] cnt, cnt_n, cnt_inc, len_q;
  logic [15:0] pre_q, num_q, line_n;
  logic err_n, load, active, tmo_hit, unused_tcq;
  assign unused_tcq = TCQ > 0.0;
  assign cnt_inc = cnt + 32'd1;
  assign active = state inside {PRE, LINE, GAP};
  assign state_o = state;
`ifdef SCAN_TIMEOUT_EN
  logic [31:0] tmo_q, sess;
  assign tmo_hit = active && tmo_q != '0 && sess + 32'd1 == tmo_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_q <= '0;
      sess <= '0;
    end else begin
      if (load) tmo_q <= cfg_timeout_i;
      sess <= active ? sess + {31'd0, sess != '1} : '0;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^cfg_timeout_i;
  assign tmo_hit = 1'b0;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt_inc;
    line_n = line_cnt_o;
    err_n = scan_err_o | tmo_hit;
    load = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (scan_start_i && !scan_stop_i) begin
          load = cfg_line_len_i != '0 && cfg_line_num_i != '0;
          err_n = !load;
          line_n = load ? '0 : line_cnt_o;
          state_n = load ? PRE : IDLE;
        end
      end
      PRE: if (cnt_inc >= {16'd0, pre_q}) begin
        state_n = LINE;
        cnt_n = '0;
      end
      LINE: if (cnt_inc == len_q) begin
        line_n = line_cnt_o + 16'd1;
        state_n = line_n == num_q ? END : GAP;
        cnt_n = '0;
      end
      GAP: if (cnt_inc == LINE_GAP) begin
        state_n = LINE;
        cnt_n = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
    // abort and watchdog win over any phase transition; a partial line is never counted
    if (active && (scan_stop_i || tmo_hit)) begin
      state_n = END;
      cnt_n = '0;
      line_n = line_cnt_o;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt <= '0;
      pre_q <= '0;
      len_q <= '0;
      num_q <= '0;
      line_cnt_o <= '0;
      scan_err_o <= 1'b0;
      adc_start_en_o <= 1'b0;
      adc_end_en_o <= 1'b0;
      scan_done_o <= 1'b0;
      scan_busy_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      line_cnt_o <= line_n;
      scan_err_o <= err_n;
      adc_start_en_o <= state_n == LINE;
      adc_end_en_o <= state_n == END;
      scan_done_o <= state_n == END;
      scan_busy_o <= state_n != IDLE;
      if (load) begin
        pre_q <= cfg_pre_delay_i;
        len_q <= cfg_line_len_i;
        num_q <= cfg_line_num_i;
      end
    end
  end
endmodule

// File: tb/tb_pmt_scan_ctrl.sv
// tb_pmt_scan_ctrl: randomized scan sessions checked cycle by cycle against a timeline model.
module tb_pmt_scan_ctrl;
  localparam int GAP = 8;
  logic clk_i = 1'b0, rst_n_i = 1'b0, scan_start_i = 1'b0, scan_stop_i = 1'b0;
  logic [15:0] cfg_pre_delay_i = '0, cfg_line_num_i = '0;
  logic [31:0] cfg_line_len_i = '0, cfg_timeout_i = '0;
  logic adc_start_en_o, adc_end_en_o, scan_busy_o, scan_done_o, scan_err_o;
  logic [15:0] line_cnt_o;
  logic [2:0] state_o;
  int tests = 0, fails = 0;
  typedef struct packed {logic [2:0] st; logic [15:0] lc; logic er;} exp_t;
  exp_t exp_q[$];
  pmt_scan_ctrl #(.LINE_GAP(GAP)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .scan_start_i(scan_start_i), .scan_stop_i(scan_stop_i),
    .cfg_pre_delay_i(cfg_pre_delay_i), .cfg_line_len_i(cfg_line_len_i),
    .cfg_line_num_i(cfg_line_num_i), .cfg_timeout_i(cfg_timeout_i),
    .adc_start_en_o(adc_start_en_o), .adc_end_en_o(adc_end_en_o), .scan_busy_o(scan_busy_o),
    .scan_done_o(scan_done_o), .scan_err_o(scan_err_o), .line_cnt_o(line_cnt_o), .state_o(state_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask
  task automatic check_cycle(input string tag, input exp_t e);
    check({tag, " state"}, 32'(state_o), 32'(e.st));
    check({tag, " busy"}, 32'(scan_busy_o), 32'(e.st != 3'd0));
    check({tag, " adc_start"}, 32'(adc_start_en_o), 32'(e.st == 3'd2));
    check({tag, " adc_end"}, 32'(adc_end_en_o), 32'(e.st == 3'd4));
    check({tag, " done"}, 32'(scan_done_o), 32'(e.st == 3'd4));
    check({tag, " line_cnt"}, 32'(line_cnt_o), 32'(e.lc));
    check({tag, " err"}, 32'(scan_err_o), 32'(e.er));
  endtask
  // Lay out the whole nominal session as a list of phases, then cut it at the abort cycle.
  task automatic build(input int pre, input int len, input int num, input int cut, input bit cut_err);
    exp_t tl[$];
    exp_t e;
    for (int i = 0; i < (pre == 0 ? 1 : pre); i++) tl.push_back('{3'd1, 16'd0, 1'b0});
    for (int l = 0; l < num; l++) begin
      for (int i = 0; i < len; i++) tl.push_back('{3'd2, 16'(l), 1'b0});
      if (l < num - 1) for (int i = 0; i < GAP; i++) tl.push_back('{3'd3, 16'(l + 1), 1'b0});
    end
    tl.push_back('{3'd4, 16'(num), 1'b0});
    if (cut >= 0 && cut < tl.size() && tl[cut].st != 3'd4) begin
      e = '{3'd4, tl[cut].lc, cut_err};
      tl = tl[0:cut];
      tl.push_back(e);
    end
    exp_q = tl;
    e = exp_q[$];
    e.st = 3'd0;
    repeat (2) exp_q.push_back(e);
  endtask
  task automatic run_session(input string name, input int pre, input int len, input int num,
                             input int cut, input bit by_stop, input bit noise, input logic [31:0] tmo);
    build(pre, len, num, cut, !by_stop);
    cfg_pre_delay_i = 16'(pre);
    cfg_line_len_i = 32'(len);
    cfg_line_num_i = 16'(num);
    cfg_timeout_i = tmo;
    scan_start_i = 1'b1;
    @(posedge clk_i); #1;
    for (int j = 0; j < exp_q.size(); j++) begin
      check_cycle($sformatf("%s[%0d]", name, j), exp_q[j]);
      scan_stop_i = by_stop && j == cut;
      scan_start_i = noise && exp_q[j].st != 3'd0 && $urandom_range(0, 3) == 0;
      if (noise && exp_q[j].st != 3'd0) begin
        cfg_pre_delay_i = 16'($urandom);
        cfg_line_len_i = $urandom_range(0, 40);
        cfg_line_num_i = 16'($urandom_range(0, 3));
        cfg_timeout_i = $urandom_range(0, 50);
      end
      @(posedge clk_i); #1;
    end
    scan_stop_i = 1'b0;
    scan_start_i = 1'b0;
  endtask
  task automatic idle_start(input string name, input logic [15:0] num, input bit stop, input bit want_err);
    cfg_line_len_i = 32'd4;
    cfg_line_num_i = num;
    scan_start_i = 1'b1;
    scan_stop_i = stop;
    @(posedge clk_i); #1;
    scan_start_i = 1'b0;
    scan_stop_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s[%0d] state", name, k), 32'(state_o), 32'd0);
      check($sformatf("%s[%0d] busy", name, k), 32'(scan_busy_o), 32'd0);
      check($sformatf("%s[%0d] adc_start", name, k), 32'(adc_start_en_o), 32'd0);
      check($sformatf("%s[%0d] err", name, k), 32'(scan_err_o), 32'(want_err));
      @(posedge clk_i); #1;
    end
  endtask
  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check_cycle("reset", '{3'd0, 16'd0, 1'b0});
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    check_cycle("post_reset", '{3'd0, 16'd0, 1'b0});
    run_session("nominal", 5, 10, 3, -1, 1'b1, 1'b0, 32'd0);
    run_session("busy_start", 5, 10, 3, -1, 1'b1, 1'b1, 32'd0);
    run_session("abort", 5, 10, 5, 26, 1'b1, 1'b0, 32'd0);
    run_session("pre0", 0, 1, 1, -1, 1'b1, 1'b0, 32'd0);
    run_session("stop_pre", 3, 4, 2, 0, 1'b1, 1'b0, 32'd0);
    idle_start("bad_num", 16'd0, 1'b0, 1'b1);
    cfg_line_num_i = 16'd2;
    cfg_line_len_i = 32'd0;
    scan_start_i = 1'b1;
    @(posedge clk_i); #1;
    scan_start_i = 1'b0;
    check("bad_len err", 32'(scan_err_o), 32'd1);
    check("bad_len busy", 32'(scan_busy_o), 32'd0);
    idle_start("start_stop_keep_err", 16'd3, 1'b1, 1'b1);
    run_session("clear_err", 2, 3, 2, -1, 1'b1, 1'b0, 32'd0);
    idle_start("start_stop_no_err", 16'd0, 1'b1, 1'b0);
    for (int s = 0; s < 25; s++)
      run_session($sformatf("rand%0d", s), $urandom_range(0, 6), $urandom_range(1, 12),
                   $urandom_range(1, 5), $urandom_range(0, 3) == 0 ? -1 : $urandom_range(0, 100),
                   1'b1, 1'b1, 32'd0);
`ifdef SCAN_TIMEOUT_EN
    run_session("timeout", 5, 100, 10, 299, 1'b0, 1'b0, 32'd300);
`endif
    cfg_pre_delay_i = 16'd2;
    cfg_line_len_i = 32'd20;
    cfg_line_num_i = 16'd2;
    cfg_timeout_i = 32'd0;
    scan_start_i = 1'b1;
    @(posedge clk_i); #1;
    scan_start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    check("rst_line pre state", 32'(state_o), 32'd2);
    check("rst_line pre adc", 32'(adc_start_en_o), 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    check_cycle("rst_async", '{3'd0, 16'd0, 1'b0});
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_i); #1;
      if (k == 2) rst_n_i = 1'b1;
      check($sformatf("rst_after[%0d] adc_end", k), 32'(adc_end_en_o), 32'd0);
      check($sformatf("rst_after[%0d] busy", k), 32'(scan_busy_o), 32'd0);
      check($sformatf("rst_after[%0d] state", k), 32'(state_o), 32'd0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
